// File: rtl/io_pkg.sv
// Shared constants and types for the I/O seven-segment scan block.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package io_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DIG_W      = $clog2(NUM_DIGITS);
    localparam int PORT_W     = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [NUM_DIGITS-1:0] an_n;
        logic [6:0]            seg_n;
        logic                  dp_n;
    } seg_out_t;

    localparam seg_out_t SEG_OUT_OFF = '{
        an_n:  {NUM_DIGITS{1'b1}},
        seg_n: SEG_BLANK,
        dp_n:  1'b1
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg7_hex_decode
    import io_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = HEX_SEG[i_nib];

endmodule

// File: rtl/io_seg7_scan.sv
// Eight-digit multiplexed common-anode display driver for out_port0,
// with per-frame snapshot, blank interval and leading-zero blanking.
module io_seg7_scan
    import io_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                  io_clk,
    input  logic                  clrn,
    input  logic [PORT_W-1:0]     port_in,
    input  logic [NUM_DIGITS-1:0] dp_in,
    input  logic                  blank_lead,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic                  frame_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0]         r_div_cnt;
    logic [DIG_W-1:0]      r_dig;
    logic [PORT_W-1:0]     r_shadow;
    logic [NUM_DIGITS-1:0] r_dp_shadow;
    logic                  r_init_done;
    logic                  r_frame_tick;
    seg_out_t              r_out;

    logic                  w_digit_tick;
    logic                  w_snap;
    logic                  w_blank_win;
    logic                  w_lead_zero;
    logic [PORT_W-1:0]     w_upper;
    logic [6:0]            w_hex_seg_n;
    seg_out_t              w_out;

    assign w_digit_tick = (r_div_cnt == CW'(TICK_DIV - 1));
    assign w_snap = !r_init_done ||
                    (w_digit_tick && r_dig == DIG_W'(NUM_DIGITS - 1));

    generate
        if (BLANK_CYC == 0) begin : g_noblank
            assign w_blank_win = 1'b0;
        end else begin : g_blank
            assign w_blank_win = (r_div_cnt < CW'(BLANK_CYC));
        end
    endgenerate

    // Current nibble sits at the bottom; the rest is what lies above it.
    assign w_upper = r_shadow >> {r_dig, 2'b00};

    assign w_lead_zero = blank_lead &&
                         (r_dig != '0) &&
                         (w_upper == '0);

    seg7_hex_decode u_dec (
        .i_nib   (w_upper[3:0]),
        .o_seg_n (w_hex_seg_n)
    );

    always_comb begin
        w_out = SEG_OUT_OFF;
        if (!w_blank_win) begin
            w_out.an_n  = ~(NUM_DIGITS'(1) << r_dig);
            w_out.seg_n = w_lead_zero ? SEG_BLANK : w_hex_seg_n;
            w_out.dp_n  = ~r_dp_shadow[r_dig];
        end
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_div_cnt <= '0;
            r_dig     <= '0;
        end else if (w_digit_tick) begin
            r_div_cnt <= '0;
            r_dig     <= r_dig + DIG_W'(1);
        end else begin
            r_div_cnt <= r_div_cnt + CW'(1);
        end
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_shadow     <= '0;
            r_dp_shadow  <= '0;
            r_init_done  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_init_done  <= 1'b1;
            r_frame_tick <= w_snap;
            if (w_snap) begin
                r_shadow    <= port_in;
                r_dp_shadow <= dp_in;
            end
        end
    end

    always_ff @(posedge io_clk or negedge clrn) begin
        if (!clrn) begin
            r_out <= SEG_OUT_OFF;
        end else begin
            r_out <= w_out;
        end
    end

    assign an_n       = r_out.an_n;
    assign seg_n      = r_out.seg_n;
    assign dp_n       = r_out.dp_n;
    assign frame_tick = r_frame_tick;

endmodule
